// File: rtl/icache_if.sv
// Fetch-side and backing-memory signals of the instruction cache, bundled for port use.
// The cache instantiates the slave modport; the fetch stage/memory side uses master.
interface icache_if;
    logic        fetch_valid;
    logic [31:0] fetch_addr;
    logic [31:0] instr;
    logic        stall;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    modport slave (
        input  fetch_valid, fetch_addr, flush, mem_ready, mem_rdata,
        output instr, stall, mem_req, mem_addr, hit_count, miss_count
    );

    modport master (
        output fetch_valid, fetch_addr, flush, mem_ready, mem_rdata,
        input  instr, stall, mem_req, mem_addr, hit_count, miss_count
    );
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: combinational hit path, line fill on miss
// through a req/ready memory handshake, full flush, and hit/miss performance counters.
module icache_ctrl #(
    parameter int SETS           = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic     clk,
    input  logic     rst,
    icache_if.slave  bus
);
    localparam int WB    = $clog2(WORDS_PER_LINE);
    localparam int IB    = $clog2(SETS);
    localparam int OFF   = WB + 2;
    localparam int TAG_W = 32 - OFF - IB;

    typedef enum logic {IDLE, FILL} state_t;

    state_t             state_reg;
    logic [SETS-1:0]    valid_reg;
    logic [IB-1:0]      fill_idx_reg;
    logic [TAG_W-1:0]   fill_tag_reg;
    logic [WB-1:0]      word_reg;
    logic               mem_req_reg;
    logic [31:0]        mem_addr_reg;
    logic [31:0]        hit_count_reg;
    logic [31:0]        miss_count_reg;

    logic [31:0]        data_mem [SETS*WORDS_PER_LINE];
    logic [TAG_W-1:0]   tag_mem  [SETS];

    logic [WB-1:0]      word_sel;
    logic [IB-1:0]      idx;
    logic [TAG_W-1:0]   tag;
    logic               hit;
    logic               fill_we;
    logic               last_word;
    logic               unused_addr_bits;

    assign word_sel         = bus.fetch_addr[OFF-1:2];
    assign idx              = bus.fetch_addr[OFF+IB-1:OFF];
    assign tag              = bus.fetch_addr[31:OFF+IB];
    assign unused_addr_bits = ^bus.fetch_addr[1:0];

    assign hit = (state_reg == IDLE) && valid_reg[idx] && (tag_mem[idx] == tag);

    assign bus.instr      = (bus.fetch_valid && hit) ? data_mem[{idx, word_sel}] : 32'd0;
    assign bus.stall      = bus.fetch_valid && ((state_reg == FILL) || !hit);
    assign bus.mem_req    = mem_req_reg;
    assign bus.mem_addr   = mem_addr_reg;
    assign bus.hit_count  = hit_count_reg;
    assign bus.miss_count = miss_count_reg;

    // Reset and flush both suppress array writes, so an aborted fill leaves no trace.
    assign fill_we   = (state_reg == FILL) && mem_req_reg && bus.mem_ready && !bus.flush && !rst;
    assign last_word = (word_reg == WB'(WORDS_PER_LINE - 1));

    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_mem[{fill_idx_reg, word_reg}] <= bus.mem_rdata;
            if (last_word) begin
                tag_mem[fill_idx_reg] <= fill_tag_reg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            valid_reg      <= '0;
            fill_idx_reg   <= '0;
            fill_tag_reg   <= '0;
            word_reg       <= '0;
            mem_req_reg    <= 1'b0;
            mem_addr_reg   <= 32'd0;
            hit_count_reg  <= 32'd0;
            miss_count_reg <= 32'd0;
        end else if (bus.flush) begin
            state_reg   <= IDLE;
            valid_reg   <= '0;
            word_reg    <= '0;
            mem_req_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.fetch_valid) begin
                        if (hit) begin
                            hit_count_reg <= hit_count_reg + 32'd1;
                        end else begin
                            state_reg      <= FILL;
                            fill_idx_reg   <= idx;
                            fill_tag_reg   <= tag;
                            word_reg       <= '0;
                            mem_req_reg    <= 1'b1;
                            mem_addr_reg   <= {bus.fetch_addr[31:OFF], {OFF{1'b0}}};
                            miss_count_reg <= miss_count_reg + 32'd1;
                        end
                    end
                end
                FILL: begin
                    if (bus.mem_ready) begin
                        // The old line is being overwritten, so it must stop hitting at once.
                        if (word_reg == '0) begin
                            valid_reg[fill_idx_reg] <= 1'b0;
                        end
                        if (last_word) begin
                            valid_reg[fill_idx_reg] <= 1'b1;
                            state_reg               <= IDLE;
                            word_reg                <= '0;
                            mem_req_reg             <= 1'b0;
                        end else begin
                            word_reg     <= word_reg + WB'(1);
                            mem_addr_reg <= mem_addr_reg + 32'd4;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: directed vector table, hand-written corner
// sequences and a randomized run, all compared against a line-level cache model.
module tb_icache_ctrl;
    localparam int SETS = 16;
    localparam int WPL  = 4;
    localparam int LINE_BYTES = WPL * 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    icache_if bus ();

    icache_ctrl #(.SETS(SETS), .WORDS_PER_LINE(WPL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_1234;
    endfunction

    assign bus.mem_rdata = rom(bus.mem_addr);

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: cache content kept per set as line base address plus words.
    bit          m_valid [SETS];
    logic [31:0] m_line  [SETS];
    logic [31:0] m_data  [SETS][WPL];
    bit          m_busy;
    logic [31:0] m_base;
    int          m_done;
    logic [31:0] m_hits;
    logic [31:0] m_misses;

    function automatic int set_of(input logic [31:0] a);
        return int'((a / LINE_BYTES) % SETS);
    endfunction

    function automatic logic [31:0] base_of(input logic [31:0] a);
        return a - (a % LINE_BYTES);
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return !m_busy && m_valid[set_of(a)] && (m_line[set_of(a)] == base_of(a));
    endfunction

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) m_valid[s] = 1'b0;
        m_busy   = 1'b0;
        m_done   = 0;
        m_hits   = 32'd0;
        m_misses = 32'd0;
    endtask

    // One clock cycle: drive inputs at negedge, check outputs, advance the model.
    task automatic cycle(input bit fv, input logic [31:0] a, input bit rdy, input bit fl,
                         input bit r, output bit o_stall, output bit o_req,
                         output logic [31:0] o_addr, output logic [31:0] o_instr);
        bit h;
        bit exp_stall;
        logic [31:0] exp_instr;
        int s;
        @(negedge clk);
        bus.fetch_valid = fv;
        bus.fetch_addr  = a;
        bus.mem_ready   = rdy;
        bus.flush       = fl;
        rst             = r;
        #1;
        h         = model_hit(a);
        exp_stall = fv && (m_busy || !h);
        exp_instr = (fv && h) ? m_data[set_of(a)][(a / 4) % WPL] : 32'd0;
        check("stall", {31'd0, bus.stall}, {31'd0, exp_stall});
        check("instr", bus.instr, exp_instr);
        check("mem_req", {31'd0, bus.mem_req}, {31'd0, m_busy});
        if (m_busy) check("mem_addr", bus.mem_addr, m_base + 32'(4 * m_done));
        check("hit_count", bus.hit_count, m_hits);
        check("miss_count", bus.miss_count, m_misses);
        o_stall = bus.stall;
        o_req   = bus.mem_req;
        o_addr  = bus.mem_addr;
        o_instr = bus.instr;
        if (r) begin
            model_reset();
        end else if (fl) begin
            for (int k = 0; k < SETS; k++) m_valid[k] = 1'b0;
            m_busy = 1'b0;
        end else if (m_busy) begin
            if (rdy) begin
                s = set_of(m_base);
                m_data[s][m_done] = rom(m_base + 32'(4 * m_done));
                if (m_done == 0) m_valid[s] = 1'b0;
                m_done++;
                if (m_done == WPL) begin
                    m_valid[s] = 1'b1;
                    m_line[s]  = m_base;
                    m_busy     = 1'b0;
                end
            end
        end else if (fv) begin
            if (h) begin
                m_hits = m_hits + 32'd1;
            end else begin
                m_busy   = 1'b1;
                m_base   = base_of(a);
                m_done   = 0;
                m_misses = m_misses + 32'd1;
            end
        end
    endtask

    // Fetch with mem_ready high until not stalled; returns the number of stalled cycles.
    task automatic fetch_until_done(input logic [31:0] a, output int stalls);
        bit st, rq;
        logic [31:0] ad, in;
        stalls = 0;
        for (int n = 0; n < 50; n++) begin
            cycle(1'b1, a, 1'b1, 1'b0, 1'b0, st, rq, ad, in);
            if (!st) begin
                check("fetch_word", in, rom({a[31:2], 2'b00}));
                return;
            end
            stalls++;
        end
        check("fetch_timeout", 32'(stalls), 32'd0);
    endtask

    typedef struct {
        bit          fv;
        logic [31:0] addr;
        bit          rdy;
        bit          exp_stall;
        bit          exp_req;
        logic [31:0] exp_addr;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t tbl [9];

    bit          o_stall, o_req;
    logic [31:0] o_addr, o_instr;
    int          stalls;
    bit          hold;
    logic [31:0] raddr;

    localparam logic [31:0] WAIT_ADDR [7] = '{32'hBFC00200, 32'hBFC00204, 32'hBFC00204,
                                               32'hBFC00204, 32'hBFC00208, 32'hBFC0020C,
                                               32'hBFC0020C};
    localparam bit WAIT_RDY [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        tbl[0] = '{1'b1, 32'hBFC00000, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0};
        tbl[1] = '{1'b1, 32'hBFC00000, 1'b1, 1'b1, 1'b1, 32'hBFC00000, 32'h0};
        tbl[2] = '{1'b1, 32'hBFC00000, 1'b1, 1'b1, 1'b1, 32'hBFC00004, 32'h0};
        tbl[3] = '{1'b1, 32'hBFC00000, 1'b1, 1'b1, 1'b1, 32'hBFC00008, 32'h0};
        tbl[4] = '{1'b1, 32'hBFC00000, 1'b1, 1'b1, 1'b1, 32'hBFC0000C, 32'h0};
        tbl[5] = '{1'b1, 32'hBFC00000, 1'b1, 1'b0, 1'b0, 32'h0, rom(32'hBFC00000)};
        tbl[6] = '{1'b1, 32'hBFC00004, 1'b1, 1'b0, 1'b0, 32'h0, rom(32'hBFC00004)};
        tbl[7] = '{1'b1, 32'hBFC00008, 1'b1, 1'b0, 1'b0, 32'h0, rom(32'hBFC00008)};
        tbl[8] = '{1'b1, 32'hBFC0000C, 1'b1, 1'b0, 1'b0, 32'h0, rom(32'hBFC0000C)};

        rst = 1'b1;
        bus.fetch_valid = 1'b0;
        bus.fetch_addr  = 32'd0;
        bus.mem_ready   = 1'b0;
        bus.flush       = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();

        // Reset state: stall follows fetch_valid, no memory traffic.
        cycle(1'b1, 32'hBFC00000, 1'b1, 1'b0, 1'b1, o_stall, o_req, o_addr, o_instr);
        check("reset_stall", {31'd0, o_stall}, 32'd1);
        check("reset_mem_addr", o_addr, 32'd0);
        cycle(1'b0, 32'hBFC00000, 1'b0, 1'b0, 1'b1, o_stall, o_req, o_addr, o_instr);
        check("reset_stall_idle", {31'd0, o_stall}, 32'd0);

        // Cold miss and line reuse.
        for (int i = 0; i < 9; i++) begin
            cycle(tbl[i].fv, tbl[i].addr, tbl[i].rdy, 1'b0, 1'b0, o_stall, o_req, o_addr, o_instr);
            $display("vec %0d addr=%h stall=%0d req=%0d mem_addr=%h instr=%h",
                     i, tbl[i].addr, o_stall, o_req, o_addr, o_instr);
            check($sformatf("vec%0d_stall", i), {31'd0, o_stall}, {31'd0, tbl[i].exp_stall});
            check($sformatf("vec%0d_req", i), {31'd0, o_req}, {31'd0, tbl[i].exp_req});
            if (tbl[i].exp_req) check($sformatf("vec%0d_addr", i), o_addr, tbl[i].exp_addr);
            check($sformatf("vec%0d_instr", i), o_instr, tbl[i].exp_instr);
        end
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, o_stall, o_req, o_addr, o_instr);
        check("reuse_hits", bus.hit_count, 32'd4);
        check("reuse_misses", bus.miss_count, 32'd1);

        // Conflict on set 0.
        fetch_until_done(32'hBFC00100, stalls);
        check("conflict_stalls", 32'(stalls), 32'd5);
        fetch_until_done(32'hBFC00000, stalls);
        check("refetch_stalls", 32'(stalls), 32'd5);
        $display("conflict miss_count=%0d", bus.miss_count);
        check("conflict_misses", bus.miss_count, 32'd3);

        // Wait states during a fill.
        cycle(1'b1, 32'hBFC00200, 1'b1, 1'b0, 1'b0, o_stall, o_req, o_addr, o_instr);
        check("wait_detect_req", {31'd0, o_req}, 32'd0);
        for (int i = 0; i < 7; i++) begin
            cycle(1'b1, 32'hBFC00200, WAIT_RDY[i], 1'b0, 1'b0, o_stall, o_req, o_addr, o_instr);
            $display("wait %0d rdy=%0d mem_addr=%h", i, WAIT_RDY[i], o_addr);
            check($sformatf("wait%0d_addr", i), o_addr, WAIT_ADDR[i]);
            check($sformatf("wait%0d_stall", i), {31'd0, o_stall}, 32'd1);
        end
        cycle(1'b1, 32'hBFC00200, 1'b1, 1'b0, 1'b0, o_stall, o_req, o_addr, o_instr);
        check("wait_done_stall", {31'd0, o_stall}, 32'd0);
        check("wait_done_instr", o_instr, rom(32'hBFC00200));

        // Flush in the third fill cycle.
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, o_stall, o_req, o_addr, o_instr);
        cycle(1'b1, 32'h00001230, 1'b1, 1'b0, 1'b0, o_stall, o_req, o_addr, o_instr);
        cycle(1'b1, 32'h00001230, 1'b1, 1'b0, 1'b0, o_stall, o_req, o_addr, o_instr);
        cycle(1'b1, 32'h00001230, 1'b1, 1'b0, 1'b0, o_stall, o_req, o_addr, o_instr);
        cycle(1'b1, 32'h00001230, 1'b1, 1'b1, 1'b0, o_stall, o_req, o_addr, o_instr);
        check("flush_cycle_req", {31'd0, o_req}, 32'd1);
        cycle(1'b1, 32'h00001230, 1'b1, 1'b0, 1'b0, o_stall, o_req, o_addr, o_instr);
        $display("after flush req=%0d stall=%0d", o_req, o_stall);
        check("flush_req_drop", {31'd0, o_req}, 32'd0);
        check("flush_remiss", {31'd0, o_stall}, 32'd1);
        fetch_until_done(32'h00001230, stalls);
        check("flush_refill_stalls", 32'(stalls), 32'd4);
        check("flush_misses", bus.miss_count, 32'd2);

        // Reset in the second fill cycle.
        cycle(1'b1, 32'h00002344, 1'b1, 1'b0, 1'b0, o_stall, o_req, o_addr, o_instr);
        cycle(1'b1, 32'h00002344, 1'b1, 1'b0, 1'b0, o_stall, o_req, o_addr, o_instr);
        cycle(1'b1, 32'h00002344, 1'b1, 1'b0, 1'b1, o_stall, o_req, o_addr, o_instr);
        cycle(1'b0, 32'h00002344, 1'b1, 1'b0, 1'b0, o_stall, o_req, o_addr, o_instr);
        $display("after reset req=%0d mem_addr=%h misses=%0d", o_req, o_addr, bus.miss_count);
        check("rst_req", {31'd0, o_req}, 32'd0);
        check("rst_addr", o_addr, 32'd0);
        check("rst_misses", bus.miss_count, 32'd0);
        fetch_until_done(32'h00002344, stalls);
        check("rst_refill_stalls", 32'(stalls), 32'd5);

        // Hit counter wrap.
        cycle(1'b0, 32'h00002344, 1'b0, 1'b0, 1'b0, o_stall, o_req, o_addr, o_instr);
        force dut.hit_count_reg = 32'hFFFF_FFFF;
        #1;
        release dut.hit_count_reg;
        m_hits = 32'hFFFF_FFFF;
        cycle(1'b1, 32'h00002344, 1'b0, 1'b0, 1'b0, o_stall, o_req, o_addr, o_instr);
        cycle(1'b0, 32'h00002344, 1'b0, 1'b0, 1'b0, o_stall, o_req, o_addr, o_instr);
        $display("wrap hit_count=%h", bus.hit_count);
        check("hit_wrap", bus.hit_count, 32'd0);

        // Randomized traffic over a small address pool to mix hits, conflicts and flushes.
        raddr = 32'h0001_0000;
        for (int n = 0; n < 3000; n++) begin
            hold = o_stall && ($urandom_range(0, 9) < 8);
            if (!hold) begin
                raddr = (($urandom_range(0, 1) == 0) ? 32'h0001_0000 : 32'h0002_0000)
                      | (32'($urandom_range(0, 3)) << 4)
                      | (32'($urandom_range(0, 3)) << 2)
                      | 32'($urandom_range(0, 3));
            end
            cycle($urandom_range(0, 9) < 8, raddr, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 99) < 3, $urandom_range(0, 299) == 0,
                  o_stall, o_req, o_addr, o_instr);
        end
        $display("random done hits=%0d misses=%0d", bus.hit_count, bus.miss_count);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
